// File: rtl/tsc_display_pkg.sv
// Shared constants for the 4-digit hex display scanner: digit count,
// scan FSM encoding and the active-low seven-segment code table.
package tsc_display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = $clog2(NUM_DIGITS);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  localparam logic [6:0]            SEG_OFF = 7'b1111111;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = '1;

  // {g,f,e,d,c,b,a}, active-low; element 0 is the rightmost entry.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,  // F E d C
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,  // b A 9 8
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,  // 7 6 5 4
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000   // 3 2 1 0
  };

  function automatic logic [NUM_DIGITS-1:0] anode_sel(input logic [DIGIT_W-1:0] idx);
    return ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7
  import tsc_display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/hex_display_scan.sv
// Time-multiplexed 4-digit hex display driver with a blanking slot per digit,
// PC LED mirror and a retriggerable update-indicator pulse.
module hex_display_scan
  import tsc_display_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int FLASH_CYCLES = 5000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] output_port,
  input  logic        update,
  input  logic [7:0]  PC_below8bit,
  input  logic        blank,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic [7:0]  led,
  output logic        upd_flag
);

  localparam int SLOT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FLASH_W = $clog2(FLASH_CYCLES + 1);
  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [FLASH_W-1:0] FLASH_LOAD = FLASH_W'(FLASH_CYCLES);

  logic [15:0]         r_disp_val;
  logic [SLOT_W-1:0]   r_slot_cnt;
  logic [SLOT_W-1:0]   w_slot_next;
  logic [DIGIT_W-1:0]  r_digit_idx;
  logic [DIGIT_W-1:0]  w_idx_next;
  scan_state_e         r_state;
  scan_state_e         w_state_next;
  logic [FLASH_W-1:0]  r_flash_cnt;
  logic [FLASH_W-1:0]  w_flash_next;
  logic [3:0]          w_nibble;
  logic [6:0]          w_seg_code;
  logic [6:0]          r_seg;
  logic [3:0]          r_an;
  logic [7:0]          r_led;
  logic                r_upd_flag;

  // NOTE: every signal driven from always_comb gets a default first so no path
  // through the block can leave it holding a value, which would infer a latch.
  always_comb begin
    w_slot_next  = r_slot_cnt + SLOT_W'(1);
    w_idx_next   = r_digit_idx;
    if (r_slot_cnt == SLOT_LAST) begin
      w_slot_next = '0;
      w_idx_next  = r_digit_idx + DIGIT_W'(1);
    end
    w_state_next = (w_slot_next == '0) ? ST_BLANK : ST_SHOW;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_BLANK;
    else          r_state <= w_state_next;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_slot_cnt  <= '0;
      r_digit_idx <= '0;
    end else begin
      r_slot_cnt  <= w_slot_next;
      r_digit_idx <= w_idx_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_disp_val <= '0;
    else if (update) r_disp_val <= output_port;
  end

  always_comb begin
    w_nibble = r_disp_val[3:0];
    case (r_digit_idx)
      2'd1:    w_nibble = r_disp_val[7:4];
      2'd2:    w_nibble = r_disp_val[11:8];
      2'd3:    w_nibble = r_disp_val[15:12];
      default: w_nibble = r_disp_val[3:0];
    endcase
  end

  hex_to_seg7 u_hex_to_seg7 (
    .i_nibble (w_nibble),
    .o_seg    (w_seg_code)
  );

  // Outputs follow the slot position held before the edge, so the first
  // edge after reset presents the blanking slot of digit 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
      r_led <= '0;
    end else begin
      r_led <= PC_below8bit;
      if (blank || (r_state == ST_BLANK)) begin
        r_an  <= AN_OFF;
        r_seg <= SEG_OFF;
      end else begin
        r_an  <= anode_sel(r_digit_idx);
        r_seg <= w_seg_code;
      end
    end
  end

  always_comb begin
    w_flash_next = r_flash_cnt;
    if (update)                w_flash_next = FLASH_LOAD;
    else if (r_flash_cnt != '0) w_flash_next = r_flash_cnt - FLASH_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flash_cnt <= '0;
      r_upd_flag  <= 1'b0;
    end else begin
      r_flash_cnt <= w_flash_next;
      r_upd_flag  <= (w_flash_next != '0);
    end
  end

  assign seg      = r_seg;
  assign an       = r_an;
  assign led      = r_led;
  assign upd_flag = r_upd_flag;

endmodule

// File: tb/tb_hex_display_scan.sv
// Scoreboard bench for hex_display_scan with REFRESH_DIV=4, FLASH_CYCLES=8.
module tb_hex_display_scan;

  logic        clk;
  logic        reset_n;
  logic [15:0] output_port;
  logic        update;
  logic [7:0]  PC_below8bit;
  logic        blank;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [7:0]  led;
  logic        upd_flag;

  hex_display_scan #(
    .REFRESH_DIV  (4),
    .FLASH_CYCLES (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .output_port  (output_port),
    .update       (update),
    .PC_below8bit (PC_below8bit),
    .blank        (blank),
    .seg          (seg),
    .an           (an),
    .led          (led),
    .upd_flag     (upd_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      name;
    logic [3:0] an;
    logic [6:0] seg;
    logic       flag;
    logic [7:0] led;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Hand-entered decode table (index = nibble) and anode pattern per
  // position within a 16-cycle scan frame.
  logic [6:0] seg_codes [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  logic [3:0] an_tab [16] = '{
    4'b1111, 4'b1110, 4'b1110, 4'b1110,
    4'b1111, 4'b1101, 4'b1101, 4'b1101,
    4'b1111, 4'b1011, 4'b1011, 4'b1011,
    4'b1111, 4'b0111, 4'b0111, 4'b0111
  };

  logic [15:0] cur_val  = '0;
  int          last_upd = 0;
  bit          upd_seen = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check(input string what, input int c, input logic [7:0] got,
                       input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %b want %b", what, c, got, want);
    end
  endtask

  // Monitor: compares every expectation tagged with the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s stale expectation cyc %0d seen at cyc %0d", mon_e.name, mon_e.cyc, cyc);
      end else begin
        check({mon_e.name, ".an"},   cyc, {4'b0, an},       {4'b0, mon_e.an});
        check({mon_e.name, ".seg"},  cyc, {1'b0, seg},      {1'b0, mon_e.seg});
        check({mon_e.name, ".flag"}, cyc, {7'b0, upd_flag}, {7'b0, mon_e.flag});
        check({mon_e.name, ".led"},  cyc, led,              mon_e.led);
      end
    end
  end

  task automatic push_reset_exp(input string name);
    exp_t e;
    e.cyc = 0; e.name = name; e.an = 4'b1111; e.seg = 7'b1111111;
    e.flag = 1'b0; e.led = 8'h00;
    sb.push_back(e);
  endtask

  // Drive one cycle of stimulus and queue the outputs expected after the next edge.
  task automatic step(input bit upd, input logic [15:0] val, input bit blk,
                      input logic [7:0] pc, input string name);
    exp_t        e;
    int          k;
    int          p;
    logic [15:0] sh;
    k = cyc + 1;
    p = k - 1;
    update       = upd;
    output_port  = val;
    blank        = blk;
    PC_below8bit = pc;
    if (upd) begin
      last_upd = k;
      upd_seen = 1'b1;
    end
    sh     = cur_val >> (4 * ((p / 4) % 4));
    e.cyc  = k;
    e.name = name;
    e.an   = blk ? 4'b1111 : an_tab[p % 16];
    e.seg  = (blk || an_tab[p % 16] == 4'b1111) ? 7'b1111111 : seg_codes[sh[3:0]];
    e.flag = upd_seen && ((k - last_upd) < 8);
    e.led  = pc;
    sb.push_back(e);
    if (upd) cur_val = val;
    @(negedge clk);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset_n      = 1'b0;
    update       = 1'b0;
    output_port  = '0;
    blank        = 1'b0;
    PC_below8bit = '0;
    #12;
    push_reset_exp("reset");
    @(negedge clk);
    #2 reset_n = 1'b1;

    // Idle scan: digit 0 blank slot first, every SHOW slot displays '0'.
    for (int i = 0; i < 16; i++) step(1'b0, 16'h0000, 1'b0, 8'(8'h30 + i), "idle_scan");

    // 12AF: held while output_port changes without update.
    step(1'b1, 16'h12AF, 1'b0, 8'h51, "upd_12af");
    for (int i = 0; i < 15; i++) step(1'b0, 16'hDEAD, 1'b0, 8'(8'h60 + i), "show_12af");

    // Back to 0000, then 0008 loaded on the edge where digit 3 hands over to digit 0.
    step(1'b1, 16'h0000, 1'b0, 8'h70, "upd_zero");
    for (int i = 0; i < 14; i++) step(1'b0, 16'h0000, 1'b0, 8'(8'h71 + i), "show_zero");
    step(1'b1, 16'h0008, 1'b0, 8'h80, "upd_on_digit_change");
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 1'b0, 8'(8'h81 + i), "show_8");

    // Retrigger: second update 5 cycles after the first keeps the flag high 13 cycles.
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 1'b0, 8'(8'h90 + i), "flash_idle");
    step(1'b1, 16'h0008, 1'b0, 8'h94, "flash_first");
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 1'b0, 8'(8'h95 + i), "flash_run");
    step(1'b1, 16'h0008, 1'b0, 8'h99, "flash_retrig");
    for (int i = 0; i < 10; i++) step(1'b0, 16'h0000, 1'b0, 8'(8'hA0 + i), "flash_tail");

    // Blank for 10 cycles with an update captured underneath.
    for (int i = 0; i < 10; i++)
      step(i == 2, 16'h4321, 1'b1, 8'(8'hB0 + i), "blanked");
    for (int i = 0; i < 10; i++) step(1'b0, 16'h0000, 1'b0, 8'(8'hC0 + i), "after_blank");

    // Asynchronous reset between edges during an active flash pulse.
    step(1'b1, 16'hBEEF, 1'b0, 8'hD0, "pre_reset_upd");
    step(1'b0, 16'h0000, 1'b0, 8'hD1, "pre_reset");
    @(posedge clk);
    #2;
    PC_below8bit = 8'h1B;
    reset_n      = 1'b0;
    push_reset_exp("async_reset");
    cur_val  = '0;
    upd_seen = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b1;
    step(1'b0, 16'h0000, 1'b0, 8'h1B, "post_reset_led");
    for (int i = 0; i < 8; i++) step(1'b0, 16'h0000, 1'b0, 8'(8'hE0 + i), "post_reset_scan");

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
